// File: rtl/des_f_sbox_sequencer.sv
// DES round f-function sequencer: expands R, mixes in the subkey, addresses the
// eight external S-box ROMs, then permutes their outputs onto a valid/ready port.
module des_f_sbox_sequencer #(
  parameter int ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey_in,
  output logic [15:0] sbox_row,
  output logic [31:0] sbox_col,
  input  logic [31:0] sbox_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] f_out
);

  typedef enum logic [1:0] {IDLE, ADDR, OUT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(ROM_LATENCY);

  state_t      state;
  logic [2:0]  cnt;
  logic [47:0] x;

  // Vector bit 31 is DES bit 1, so DES bit n lives at index 32-n.
  function automatic logic [47:0] expand(input logic [31:0] r);
    return {r[0],  r[31:27],
            r[28:23], r[24:19], r[20:15], r[16:11],
            r[12:7],  r[8:3],
            r[4:0],  r[31]};
  endfunction

  function automatic logic [31:0] permute(input logic [31:0] s);
    return {s[16], s[25], s[12], s[11], s[3],  s[20], s[4],  s[15],
            s[31], s[17], s[9],  s[6],  s[27], s[14], s[1],  s[22],
            s[30], s[24], s[8],  s[18], s[0],  s[5],  s[29], s[23],
            s[13], s[19], s[2],  s[26], s[10], s[21], s[28], s[7]};
  endfunction

  // ROM addresses come only from the registered x, never from r_in directly.
  for (genvar g = 0; g < 8; g++) begin : g_addr
    assign sbox_row[15-2*g -: 2] = {x[47-6*g], x[42-6*g]};
    assign sbox_col[31-4*g -: 4] = x[46-6*g -: 4];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      f_out     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x        <= expand(r_in) ^ subkey_in;
            cnt      <= CNT_INIT;
            in_ready <= 1'b0;
            state    <= ADDR;
          end
        end
        // cnt counts the ROM read latency down; dout is valid once it hits zero.
        ADDR: begin
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            f_out     <= permute(sbox_dout);
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_f_sbox_sequencer.sv
// Scoreboard bench for des_f_sbox_sequencer with behavioural DES S-box ROMs
// (one 1-cycle ROM bank, one 3-stage ROM bank on a ROM_LATENCY=3 instance).
module tb_des_f_sbox_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] r_in, sbox_col, sbox_dout, f_out;
  logic [47:0] subkey_in;
  logic [15:0] sbox_row;

  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] r_in3, sbox_col3, sbox_dout3, f_out3, rom_p1, rom_p2;
  logic [47:0] subkey_in3;
  logic [15:0] sbox_row3;

  logic [63:0] s_tab [0:31];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  logic [31:0] exp_q[$], exp_q3[$];
  int          acc_q[$], acc_q3[$];
  bit          busy, prev_ov, prev_or, pend_bubble, prev_ov3, done3, ok3;
  int          hs_edge;

  localparam logic [31:0] KR = 32'hF0AAF0AA;
  localparam logic [47:0] KK = 48'h1B02EFFC7072;
  localparam logic [31:0] KF = 32'h234AA9BB;
  localparam logic [31:0] ZF = 32'hD8D8DBBC;

  des_f_sbox_sequencer #(.ROM_LATENCY(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .r_in(r_in), .subkey_in(subkey_in), .sbox_row(sbox_row), .sbox_col(sbox_col),
    .sbox_dout(sbox_dout), .out_valid(out_valid), .out_ready(out_ready), .f_out(f_out)
  );

  des_f_sbox_sequencer #(.ROM_LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid3), .in_ready(in_ready3),
    .r_in(r_in3), .subkey_in(subkey_in3), .sbox_row(sbox_row3), .sbox_col(sbox_col3),
    .sbox_dout(sbox_dout3), .out_valid(out_valid3), .out_ready(out_ready3), .f_out(f_out3)
  );

  initial begin
    s_tab = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
  end

  function automatic logic [31:0] rom_lookup(input logic [15:0] row, input logic [31:0] col);
    logic [31:0] res;
    logic [63:0] line;
    int r, c;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      r = int'(row[15-2*i -: 2]);
      c = int'(col[31-4*i -: 4]);
      line = s_tab[i*4 + r];
      res[31-4*i -: 4] = line[63-4*c -: 4];
    end
    return res;
  endfunction

  // ROM models with synchronous reset: one registered stage, and a 3-deep pipeline.
  always @(posedge clk) begin
    if (!rstn) begin
      sbox_dout  <= '0;
      rom_p1     <= '0;
      rom_p2     <= '0;
      sbox_dout3 <= '0;
    end else begin
      sbox_dout  <= rom_lookup(sbox_row, sbox_col);
      rom_p1     <= rom_lookup(sbox_row3, sbox_col3);
      rom_p2     <= rom_p1;
      sbox_dout3 <= rom_p2;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the ROM_LATENCY=1 instance, sampling between edges.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      acc_q.delete();
      busy = 0; prev_ov = 0; prev_or = 1; pend_bubble = 0;
    end else begin
      if (busy) check_output("in_ready_busy", 48'(in_ready), 48'(0));
      if (prev_ov && !prev_or) check_output("out_valid_hold", 48'(out_valid), 48'(1));
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) check_output("spurious_out_valid", 48'(out_valid), 48'(0));
        else check_output("latency", 48'(cyc - acc_q.pop_front()), 48'(2));
      end
      if (out_valid) begin
        if (exp_q.size() != 0) check_output("f_out", 48'(f_out), 48'(exp_q[0]));
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          busy = 0;
          if (in_valid) begin
            pend_bubble = 1;
            hs_edge = cyc + 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_q.push_back(cyc + 1);
        busy = 1;
        if (pend_bubble) begin
          check_output("bubble", 48'(cyc + 1 - hs_edge), 48'(1));
          pend_bubble = 0;
        end
      end
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q3.delete();
      acc_q3.delete();
      prev_ov3 = 0;
    end else begin
      if (out_valid3 && !prev_ov3) begin
        if (acc_q3.size() == 0) check_output("spurious_out_valid3", 48'(out_valid3), 48'(0));
        else check_output("latency3", 48'(cyc - acc_q3.pop_front()), 48'(4));
      end
      if (out_valid3 && out_ready3 && exp_q3.size() != 0)
        check_output("f_out3", 48'(f_out3), 48'(exp_q3.pop_front()));
      if (in_valid3 && in_ready3) acc_q3.push_back(cyc + 1);
      prev_ov3 = out_valid3;
    end
  end

  task automatic apply_stimulus(input logic [31:0] r, input logic [47:0] k,
                                input logic [31:0] exp, input bit drop);
    bit ok;
    ok = 0;
    r_in = r;
    subkey_in = k;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check_output("accept_timeout", 48'(in_ready), 48'(1));
    step();
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && in_ready && !out_valid) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) check_output("idle_timeout", 48'(exp_q.size()), 48'(0));
  endtask

  // Second instance: ROM_LATENCY=3 against the 3-stage ROM pipeline.
  initial begin
    in_valid3 = 0; r_in3 = '0; subkey_in3 = '0; out_ready3 = 1; done3 = 0; ok3 = 0;
    repeat (5) step();
    r_in3 = KR;
    subkey_in3 = KK;
    in_valid3 = 1;
    exp_q3.push_back(KF);
    for (int i = 0; i < 50; i++) begin
      if (in_ready3) begin
        ok3 = 1;
        break;
      end
      step();
    end
    if (!ok3) check_output("accept_timeout3", 48'(in_ready3), 48'(1));
    step();
    in_valid3 = 0;
    for (int i = 0; i < 50; i++) begin
      if (exp_q3.size() == 0) break;
      step();
    end
    done3 = 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn = 0; in_valid = 0; out_ready = 1; r_in = '0; subkey_in = '0;
    repeat (2) step();
    check_output("rst_in_ready", 48'(in_ready), 48'(0));
    check_output("rst_out_valid", 48'(out_valid), 48'(0));
    check_output("rst_f_out", 48'(f_out), 48'(0));
    check_output("rst_sbox_row", 48'(sbox_row), 48'(0));
    check_output("rst_sbox_col", 48'(sbox_col), 48'(0));
    rstn = 1;
    step();
    check_output("idle_in_ready", 48'(in_ready), 48'(1));

    $display("[TB] known vector");
    apply_stimulus(KR, KK, KF, 1);
    check_output("known_sbox_row", 48'(sbox_row), 48'(16'h12E3));
    check_output("known_sbox_col", 48'(sbox_col), 48'(32'hC8FD03A3));
    wait_idle();

    $display("[TB] all-zero vector");
    apply_stimulus('0, '0, ZF, 1);
    check_output("zero_sbox_row", 48'(sbox_row), 48'(0));
    check_output("zero_sbox_col", 48'(sbox_col), 48'(0));
    wait_idle();
    check_output("addr_hold_row", 48'(sbox_row), 48'(0));

    $display("[TB] back-pressure");
    out_ready = 0;
    apply_stimulus(KR, KK, KF, 1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      step();
    end
    repeat (10) step();
    out_ready = 1;
    wait_idle();

    $display("[TB] back-to-back");
    apply_stimulus(KR, KK, KF, 0);
    apply_stimulus('0, '0, ZF, 1);
    wait_idle();

    $display("[TB] reset mid-flight");
    apply_stimulus(KR, KK, KF, 1);
    rstn = 0;
    #1;
    check_output("midrst_out_valid", 48'(out_valid), 48'(0));
    check_output("midrst_f_out", 48'(f_out), 48'(0));
    check_output("midrst_in_ready", 48'(in_ready), 48'(0));
    check_output("midrst_sbox_col", 48'(sbox_col), 48'(0));
    step();
    rstn = 1;
    step();
    check_output("postrst_out_valid", 48'(out_valid), 48'(0));
    check_output("postrst_f_out", 48'(f_out), 48'(0));
    check_output("postrst_in_ready", 48'(in_ready), 48'(1));
    apply_stimulus(KR, KK, KF, 1);
    wait_idle();

    for (int i = 0; i < 100; i++) begin
      if (done3) break;
      step();
    end
    check_output("drain", 48'(exp_q.size()), 48'(0));
    check_output("drain3", 48'(exp_q3.size()), 48'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
